icache_mem_arbiter: RTL and testbench

Sequences I-cache miss fills and shares the single tagged memory port between the I-cache fetch path and the D-cache.
- Tracks outstanding I-cache loads in a small miss table (MSHRs) indexed by memory tag.
- Returns fill data, with its block address, to the I-cache that feeds the instruction buffer.
- Squashes in-flight wrong-path fills on a taken branch.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/icache_mshr_table.sv | 87 ++++++++
 rtl/icache_mem_arbiter.sv | 93 +++++++++
 tb/tb_icache_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-bus types: command encoding, tag width and the I-cache miss table entry.
package mem_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef struct packed {
    logic             valid;
    logic             squashed;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  blk_addr;
  } mshr_entry_t;

endpackage

// File: rtl/icache_mshr_table.sv
// Outstanding I-cache fill table: allocates on accept, matches returning tags,
// squashes on taken branches and emits a registered fill pulse for live entries.
module icache_mshr_table
  import mem_pkg::*;
#(
  parameter int NUM_MSHR = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc,
  input  logic [TAG_W-1:0] alloc_tag,
  input  logic [XLEN-1:0]  alloc_addr,
  input  logic             squash,
  input  logic [TAG_W-1:0] ret_tag,
  input  logic [63:0]      ret_data,
  output logic             full,
  output logic             fill_valid,
  output logic [XLEN-1:0]  fill_addr,
  output logic [63:0]      fill_data
);

  mshr_entry_t entry_reg [NUM_MSHR];

  logic [NUM_MSHR-1:0] free_vec;
  logic [NUM_MSHR-1:0] hit_vec;
  logic [NUM_MSHR-1:0] alloc_vec;
  logic                hit_any;
  logic                hit_squashed;
  logic [XLEN-1:0]     hit_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MSHR; gi++) begin : g_match
      assign free_vec[gi] = !entry_reg[gi].valid;
      assign hit_vec[gi]  = entry_reg[gi].valid && (ret_tag != '0) &&
                            (entry_reg[gi].tag == ret_tag);
    end
  endgenerate

  // Lowest free slot, isolated as x & -x; a slot freed this cycle is not yet visible here.
  assign alloc_vec = alloc ? (free_vec & (~free_vec + NUM_MSHR'(1))) : '0;
  assign full      = ~|free_vec;
  assign hit_any   = |hit_vec;

  always_comb begin
    hit_squashed = 1'b0;
    hit_addr     = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (hit_vec[i]) begin
        hit_squashed = entry_reg[i].squashed;
        hit_addr     = entry_reg[i].blk_addr;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (reset) begin
        entry_reg[i] <= '0;
      end else if (alloc_vec[i]) begin
        entry_reg[i].valid    <= 1'b1;
        entry_reg[i].squashed <= squash;
        entry_reg[i].tag      <= alloc_tag;
        entry_reg[i].blk_addr <= alloc_addr;
      end else if (hit_vec[i]) begin
        entry_reg[i].valid <= 1'b0;
      end else if (squash && entry_reg[i].valid) begin
        entry_reg[i].squashed <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      fill_data  <= '0;
    end else begin
      fill_valid <= hit_any && !hit_squashed && !squash;
      if (hit_any && !hit_squashed && !squash) begin
        fill_addr <= hit_addr;
        fill_data <= ret_data;
      end
    end
  end

endmodule

// File: rtl/icache_mem_arbiter.sv
// Shares the tagged memory port between I-cache miss fills and the D-cache,
// with a starvation counter that eventually forces an I-cache grant.
module icache_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_MSHR     = 4,
  parameter int TAG_W        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             icache_req_valid,
  input  logic [XLEN-1:0]  icache_req_addr,
  output logic             icache_req_accept,
  input  logic             dcache_req_valid,
  input  logic [1:0]       dcache_req_cmd,
  input  logic [XLEN-1:0]  dcache_req_addr,
  input  logic [63:0]      dcache_req_data,
  output logic             dcache_req_accept,
  output logic [TAG_W-1:0] dcache_resp_tag,
  output logic [1:0]       proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  input  logic             branch_taken,
  output logic             icache_fill_valid,
  output logic [XLEN-1:0]  icache_fill_addr,
  output logic [63:0]      icache_fill_data,
  output logic             mshr_full
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic             icache_grant;
  logic             dcache_grant;
  logic             mem_ok;
  logic [XLEN-1:0]  icache_blk_addr;

  assign icache_blk_addr = {icache_req_addr[XLEN-1:3], 3'b000};
  assign mem_ok          = mem2proc_response != '0;

  // D-cache has priority unless idle or the I-cache has been starved long enough.
  assign icache_grant = icache_req_valid && !mshr_full &&
                        (!dcache_req_valid || starve_cnt_reg == STARVE_MAX);
  assign dcache_grant = dcache_req_valid && !icache_grant;

  assign icache_req_accept = icache_grant && mem_ok;
  assign dcache_req_accept = dcache_grant && mem_ok;
  assign dcache_resp_tag   = dcache_req_accept ? mem2proc_response : '0;

  always_comb begin
    proc2mem_command = mem_pkg::BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (icache_grant) begin
      proc2mem_command = mem_pkg::BUS_LOAD;
      proc2mem_addr    = icache_blk_addr;
    end else if (dcache_grant) begin
      proc2mem_command = dcache_req_cmd;
      proc2mem_addr    = dcache_req_addr;
      proc2mem_data    = dcache_req_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !icache_req_valid || icache_req_accept) begin
      starve_cnt_reg <= '0;
    end else if (!icache_grant && starve_cnt_reg != STARVE_MAX) begin
      starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
    end
  end

  icache_mshr_table #(
    .NUM_MSHR(NUM_MSHR)
  ) u_mshr (
    .clock     (clock),
    .reset     (reset),
    .alloc     (icache_req_accept),
    .alloc_tag (mem2proc_response),
    .alloc_addr(icache_blk_addr),
    .squash    (branch_taken),
    .ret_tag   (mem2proc_tag),
    .ret_data  (mem2proc_data),
    .full      (mshr_full),
    .fill_valid(icache_fill_valid),
    .fill_addr (icache_fill_addr),
    .fill_data (icache_fill_data)
  );

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Directed bench for icache_mem_arbiter: grant, starvation, MSHR fill, squash and reset cases.
module tb_icache_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_req_accept;
  logic        dcache_req_valid;
  logic [1:0]  dcache_req_cmd;
  logic [31:0] dcache_req_addr;
  logic [63:0] dcache_req_data;
  logic        dcache_req_accept;
  logic [3:0]  dcache_resp_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic        branch_taken;
  logic        icache_fill_valid;
  logic [31:0] icache_fill_addr;
  logic [63:0] icache_fill_data;
  logic        mshr_full;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  icache_mem_arbiter dut (
    .clock            (clock),
    .reset            (reset),
    .icache_req_valid (icache_req_valid),
    .icache_req_addr  (icache_req_addr),
    .icache_req_accept(icache_req_accept),
    .dcache_req_valid (dcache_req_valid),
    .dcache_req_cmd   (dcache_req_cmd),
    .dcache_req_addr  (dcache_req_addr),
    .dcache_req_data  (dcache_req_data),
    .dcache_req_accept(dcache_req_accept),
    .dcache_resp_tag  (dcache_resp_tag),
    .proc2mem_command (proc2mem_command),
    .proc2mem_addr    (proc2mem_addr),
    .proc2mem_data    (proc2mem_data),
    .mem2proc_response(mem2proc_response),
    .mem2proc_data    (mem2proc_data),
    .mem2proc_tag     (mem2proc_tag),
    .branch_taken     (branch_taken),
    .icache_fill_valid(icache_fill_valid),
    .icache_fill_addr (icache_fill_addr),
    .icache_fill_data (icache_fill_data),
    .mshr_full        (mshr_full)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    icache_req_valid  = 1'b0;
    icache_req_addr   = '0;
    dcache_req_valid  = 1'b0;
    dcache_req_cmd    = 2'd0;
    dcache_req_addr   = '0;
    dcache_req_data   = '0;
    mem2proc_response = '0;
    mem2proc_data     = '0;
    mem2proc_tag      = '0;
    branch_taken      = 1'b0;
  endtask

  task automatic alloc_one(input logic [31:0] addr, input logic [3:0] rsp);
    icache_req_valid  = 1'b1;
    icache_req_addr   = addr;
    mem2proc_response = rsp;
    #1;
    check($sformatf("alloc_acc_t%0d", rsp), icache_req_accept, 1'b1);
    tick();
    icache_req_valid  = 1'b0;
    mem2proc_response = '0;
  endtask

  initial begin
    logic [3:0]  ret_tags  [4];
    logic [31:0] ret_addrs [4];

    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("rst_full", mshr_full, 1'b0);
    check("rst_fill_valid", icache_fill_valid, 1'b0);
    check("rst_fill_addr", icache_fill_addr, 32'h0);
    check("rst_fill_data", icache_fill_data, 64'h0);
    check("rst_cmd", proc2mem_command, 2'd0);

    // Lone I-cache miss, fill returns 5 cycles later
    icache_req_valid  = 1'b1;
    icache_req_addr   = 32'h104;
    mem2proc_response = 4'd3;
    #1;
    check("t1_cmd", proc2mem_command, 2'd1);
    check("t1_addr", proc2mem_addr, 32'h100);
    check("t1_acc", icache_req_accept, 1'b1);
    tick();
    idle_inputs();
    repeat (4) tick();
    mem2proc_tag  = 4'd3;
    mem2proc_data = 64'hDEAD;
    #1;
    check("t1_fill_early", icache_fill_valid, 1'b0);
    tick();
    mem2proc_tag  = '0;
    mem2proc_data = '0;
    #1;
    check("t1_fill_valid", icache_fill_valid, 1'b1);
    check("t1_fill_addr", icache_fill_addr, 32'h100);
    check("t1_fill_data", icache_fill_data, 64'hDEAD);
    tick();
    check("t1_fill_pulse", icache_fill_valid, 1'b0);
    check("t1_full", mshr_full, 1'b0);

    // Starvation: D-cache wins 8 cycles, I-cache forced on the 9th
    icache_req_valid  = 1'b1;
    icache_req_addr   = 32'h200;
    dcache_req_valid  = 1'b1;
    dcache_req_cmd    = 2'd1;
    dcache_req_addr   = 32'h300;
    mem2proc_response = 4'd1;
    for (int c = 1; c <= 9; c++) begin
      #1;
      if (c < 9) begin
        check($sformatf("t2_dacc_c%0d", c), dcache_req_accept, 1'b1);
        check($sformatf("t2_iacc_c%0d", c), icache_req_accept, 1'b0);
      end else begin
        check("t2_iacc_c9", icache_req_accept, 1'b1);
        check("t2_addr_c9", proc2mem_addr, 32'h200);
      end
      tick();
    end
    icache_req_addr = 32'h208;
    #1;
    check("t2_dacc_after", dcache_req_accept, 1'b1);
    check("t2_iacc_after", icache_req_accept, 1'b0);
    tick();
    idle_inputs();
    mem2proc_tag  = 4'd1;
    mem2proc_data = 64'h1111;
    tick();
    mem2proc_tag = '0;
    #1;
    check("t2_fill_valid", icache_fill_valid, 1'b1);
    check("t2_fill_addr", icache_fill_addr, 32'h200);

    // Fill the table, then free one slot while a fifth request waits
    for (int k = 1; k <= 4; k++) alloc_one(32'h1000 + 32'(k * 8), 4'(k));
    icache_req_valid  = 1'b1;
    icache_req_addr   = 32'h2000;
    mem2proc_response = 4'd5;
    mem2proc_tag      = 4'd2;
    mem2proc_data     = 64'h2222;
    #1;
    check("t3_full", mshr_full, 1'b1);
    check("t3_acc_blocked", icache_req_accept, 1'b0);
    check("t3_cmd_none", proc2mem_command, 2'd0);
    tick();
    mem2proc_tag = '0;
    #1;
    check("t3_full_freed", mshr_full, 1'b0);
    check("t3_acc_late", icache_req_accept, 1'b1);
    check("t3_fill_valid", icache_fill_valid, 1'b1);
    check("t3_fill_addr", icache_fill_addr, 32'h1010);
    check("t3_fill_data", icache_fill_data, 64'h2222);
    tick();
    idle_inputs();
    #1;
    check("t3_full_again", mshr_full, 1'b1);
    ret_tags  = '{4'd1, 4'd3, 4'd4, 4'd5};
    ret_addrs = '{32'h1008, 32'h1018, 32'h1020, 32'h2000};
    for (int k = 0; k < 4; k++) begin
      mem2proc_tag  = ret_tags[k];
      mem2proc_data = 64'(k + 64'h50);
      tick();
      #1;
      check($sformatf("t3_drain_v%0d", ret_tags[k]), icache_fill_valid, 1'b1);
      check($sformatf("t3_drain_a%0d", ret_tags[k]), icache_fill_addr, ret_addrs[k]);
    end
    mem2proc_tag = '0;
    #1;
    check("t3_drained", mshr_full, 1'b0);

    // Branch squash of two outstanding fills
    alloc_one(32'h3000, 4'd5);
    alloc_one(32'h3008, 4'd6);
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    mem2proc_tag = 4'd5;
    tick();
    #1;
    check("t4_no_fill5", icache_fill_valid, 1'b0);
    mem2proc_tag = 4'd6;
    tick();
    #1;
    check("t4_no_fill6", icache_fill_valid, 1'b0);
    mem2proc_tag = '0;
    check("t4_full", mshr_full, 1'b0);

    // Branch in the same cycle as a tag return suppresses that fill
    alloc_one(32'h6000, 4'd8);
    mem2proc_tag = 4'd8;
    branch_taken = 1'b1;
    tick();
    branch_taken = 1'b0;
    mem2proc_tag = '0;
    #1;
    check("t4b_no_fill", icache_fill_valid, 1'b0);

    // Memory rejects three times, then accepts with tag 7
    icache_req_valid = 1'b1;
    icache_req_addr  = 32'h4004;
    for (int c = 1; c <= 4; c++) begin
      mem2proc_response = (c == 4) ? 4'd7 : 4'd0;
      #1;
      check($sformatf("t5_cmd_c%0d", c), proc2mem_command, 2'd1);
      check($sformatf("t5_acc_c%0d", c), icache_req_accept, c == 4);
      tick();
    end
    idle_inputs();
    mem2proc_tag  = 4'd7;
    mem2proc_data = 64'h7777;
    tick();
    mem2proc_tag = '0;
    #1;
    check("t5_fill_valid", icache_fill_valid, 1'b1);
    check("t5_fill_addr", icache_fill_addr, 32'h4000);
    check("t5_fill_data", icache_fill_data, 64'h7777);

    // Reset mid-flight drops late responses; D-cache store gets its own tag
    alloc_one(32'h5000, 4'd2);
    alloc_one(32'h5008, 4'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("t6_full", mshr_full, 1'b0);
    check("t6_fill_addr_rst", icache_fill_addr, 32'h0);
    mem2proc_tag  = 4'd2;
    mem2proc_data = 64'h9999;
    tick();
    #1;
    check("t6_no_fill2", icache_fill_valid, 1'b0);
    mem2proc_tag = 4'd3;
    tick();
    #1;
    check("t6_no_fill3", icache_fill_valid, 1'b0);
    idle_inputs();
    dcache_req_valid  = 1'b1;
    dcache_req_cmd    = 2'd2;
    dcache_req_addr   = 32'h500;
    dcache_req_data   = 64'hABCD;
    mem2proc_response = 4'd9;
    #1;
    check("t6_dtag", dcache_resp_tag, 4'd9);
    check("t6_dacc", dcache_req_accept, 1'b1);
    check("t6_cmd", proc2mem_command, 2'd2);
    check("t6_addr", proc2mem_addr, 32'h500);
    check("t6_data", proc2mem_data, 64'hABCD);
    tick();
    idle_inputs();
    mem2proc_tag = 4'd9;
    tick();
    mem2proc_tag = '0;
    #1;
    check("t6_dtag_no_fill", icache_fill_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
